// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns an SPI byte stream into an auto-incrementing register file with a read-only status slot
module spi_reg_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ssel,
  input  logic                         byte_received,
  input  logic [7:0]                   rx_data,
  input  logic                         data_needed,
  output logic [7:0]                   tx_data,
  input  logic [7:0]                   status_in,
  output logic [8*(2**ADDR_W)-1:0]     reg_flat,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx, rd_addr;
  logic [7:0] tx_nx, rd_val;
  logic [7:0] regs [NREG];
  logic we;
  logic unused_ok;
  assign unused_ok = ^{data_needed, rx_data[6:ADDR_W]};
  assign rd_addr = state == CMD ? rx_data[ADDR_W-1:0] : addr;
  assign rd_val = rd_addr == LAST ? status_in : regs[rd_addr];
  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign reg_flat[8*k +: 8] = k == NREG-1 ? 8'h00 : regs[k];
  end
  // next state, address, transmit byte and write enable; ssel high aborts everything
  always_comb begin
    state_nx = state;
    addr_nx = addr;
    tx_nx = tx_data;
    we = 1'b0;
    if (ssel) begin
      state_nx = IDLE;
      addr_nx = '0;
      tx_nx = 8'hA5;
    end else begin
      case (state)
        IDLE: state_nx = CMD;
        CMD: if (byte_received) begin
          state_nx = rx_data[7] ? READ : WRITE;
          addr_nx = rx_data[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, rx_data[7]};
          tx_nx = rx_data[7] ? rd_val : tx_data;
        end
        WRITE: if (byte_received) begin
          we = addr != LAST;
          addr_nx = addr + 1'b1;
        end
        READ: if (byte_received) begin
          tx_nx = rd_val;
          addr_nx = addr + 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      tx_data <= 8'hA5;
      wr_pulse <= 1'b0;
      wr_addr <= '0;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      tx_data <= tx_nx;
      wr_pulse <= we;
      if (we) wr_addr <= addr;
    end
  end
  // register bank; the status slot is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[addr] <= rx_data;
    end
  end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: frame-level model of the register controller checked every cycle, plus directed literal checks
module tb_spi_reg_ctrl;
  logic clk = 0, rst_n = 0, ssel = 1, byte_received = 0, data_needed = 0, wr_pulse;
  logic [7:0] rx_data = 0, tx_data, status_in = 0;
  logic [127:0] reg_flat;
  logic [3:0] wr_addr;
  int checks = 0, errors = 0, npulse = 0, pos = 0;
  bit chk_en = 0, is_rd = 0;
  logic [3:0] start = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_tx = 8'hA5;
  logic exp_pulse = 0;
  logic [3:0] exp_waddr = 0;
  logic [7:0] miso_q [$];

  spi_reg_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ssel(ssel), .byte_received(byte_received), .rx_data(rx_data),
    .data_needed(data_needed), .tx_data(tx_data), .status_in(status_in), .reg_flat(reg_flat),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] val(input logic [3:0] k);
    return k == 4'hF ? status_in : mem[k];
  endfunction

  function automatic logic [127:0] exp_flat();
    logic [127:0] f = '0;
    for (int k = 0; k < 15; k++) f[8*k +: 8] = mem[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mem[k] = 0;
    exp_tx = 8'hA5;
    exp_pulse = 0;
    exp_waddr = 0;
    pos = 0;
  endtask

  // byte p of a frame: reads return value(start+p), writes target start+p-1, all modulo 16
  task automatic model_byte(input logic [7:0] b);
    logic [3:0] wa;
    if (pos == 0) begin
      start = b[3:0];
      is_rd = b[7];
      if (is_rd) exp_tx = val(start);
    end else if (is_rd) begin
      exp_tx = val(4'(int'(start) + pos));
    end else begin
      wa = 4'(int'(start) + pos - 1);
      if (wa != 4'hF) begin
        mem[wa] = b;
        exp_pulse = 1;
        exp_waddr = wa;
      end
    end
    pos++;
  endtask

  task automatic frame_start();
    @(negedge clk);
    ssel = 0;
    pos = 0;
    miso_q.delete();
  endtask

  task automatic frame_end();
    @(negedge clk);
    ssel = 1;
    exp_tx = 8'hA5;
  endtask

  task automatic send(input logic [7:0] b);
    repeat (3) @(negedge clk);
    miso_q.push_back(tx_data);
    rx_data = b;
    byte_received = 1;
    model_byte(b);
    @(negedge clk);
    byte_received = 0;
    exp_pulse = 0;
  endtask

  task automatic drop_end(input logic [7:0] b);
    repeat (3) @(negedge clk);
    rx_data = b;
    byte_received = 1;
    ssel = 1;
    exp_tx = 8'hA5;
    @(negedge clk);
    byte_received = 0;
  endtask

  task automatic frame(input logic [7:0] b [$]);
    frame_start();
    foreach (b[i]) send(b[i]);
    frame_end();
  endtask

  // compare process, sampled away from the clock edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (wr_pulse === 1'b1) npulse++;
      chk("tx_data", {120'b0, tx_data}, {120'b0, exp_tx});
      chk("wr_pulse", {127'b0, wr_pulse}, {127'b0, exp_pulse});
      chk("wr_addr", {124'b0, wr_addr}, {124'b0, exp_waddr});
      chk("reg_flat", reg_flat, exp_flat());
    end
  end

  initial begin
    int n0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_tx", {120'b0, tx_data}, {120'b0, 8'hA5});
    chk("reset_regs", reg_flat, '0);
    // burst write
    n0 = npulse;
    frame('{8'h02, 8'h11, 8'h22, 8'h33});
    chk("bw_miso0", {120'b0, miso_q[0]}, {120'b0, 8'hA5});
    chk("bw_reg2", {120'b0, reg_flat[23:16]}, {120'b0, 8'h11});
    chk("bw_reg3", {120'b0, reg_flat[31:24]}, {120'b0, 8'h22});
    chk("bw_reg4", {120'b0, reg_flat[39:32]}, {120'b0, 8'h33});
    chk("bw_pulses", 128'(npulse - n0), 128'd3);
    chk("bw_waddr", {124'b0, wr_addr}, {124'b0, 4'd4});
    // burst read wrapping through the status register
    frame('{8'h0E, 8'hEE});
    frame('{8'h00, 8'h5A});
    status_in = 8'hC3;
    frame('{8'h8E, 8'h00, 8'h00, 8'h00});
    chk("rd_miso0", {120'b0, miso_q[0]}, {120'b0, 8'hA5});
    chk("rd_miso1", {120'b0, miso_q[1]}, {120'b0, 8'hEE});
    chk("rd_miso2", {120'b0, miso_q[2]}, {120'b0, 8'hC3});
    chk("rd_miso3", {120'b0, miso_q[3]}, {120'b0, 8'h5A});
    // read-only status slot
    n0 = npulse;
    frame('{8'h0F, 8'h77, 8'h66});
    chk("ro_pulses", 128'(npulse - n0), 128'd1);
    chk("ro_waddr", {124'b0, wr_addr}, {124'b0, 4'd0});
    chk("ro_reg0", {120'b0, reg_flat[7:0]}, {120'b0, 8'h66});
    chk("ro_top", {120'b0, reg_flat[127:120]}, 128'd0);
    // aborted frame with a partial data byte
    frame('{8'h05, 8'h3C});
    n0 = npulse;
    frame_start();
    send(8'h05);
    repeat (5) @(negedge clk);
    frame_end();
    chk("ab_reg5", {120'b0, reg_flat[47:40]}, {120'b0, 8'h3C});
    chk("ab_pulses", 128'(npulse - n0), 128'd0);
    frame('{8'h85, 8'h00});
    chk("ab_read", {120'b0, miso_q[1]}, {120'b0, 8'h3C});
    // back-to-back frames separated by one clock of ssel high
    frame('{8'h06, 8'h9D});
    frame('{8'h83, 8'h00, 8'h00});
    chk("b2b_miso1", {120'b0, miso_q[1]}, {120'b0, 8'h22});
    chk("b2b_miso2", {120'b0, miso_q[2]}, {120'b0, 8'h33});
    // randomized frames, some ending with ssel rising on a byte
    for (int f = 0; f < 60; f++) begin
      int nb;
      bit coll;
      nb = $urandom_range(1, 6);
      coll = nb > 1 && $urandom_range(0, 4) == 0;
      status_in = 8'($urandom);
      frame_start();
      for (int i = 0; i < nb; i++) begin
        if (coll && i == nb - 1) drop_end(8'($urandom));
        else send(8'($urandom));
      end
      if (!coll) frame_end();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // reset in the middle of a write frame
    frame_start();
    send(8'h01);
    send(8'hAB);
    repeat (2) @(negedge clk);
    rst_n = 0;
    ssel = 1;
    model_reset();
    @(negedge clk);
    chk("rst_regs", reg_flat, '0);
    chk("rst_tx", {120'b0, tx_data}, {120'b0, 8'hA5});
    chk("rst_pulse", {127'b0, wr_pulse}, 128'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
